timer_mc: RTL



---
 rtl/timer_mc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/timer_mc.sv
// timer_mc: multi-channel up-counter timer behind a simple register port.
// Each channel has a prescaler, a compare value and a sticky match flag.
// The match flag drives a maskable, level-sensitive interrupt line.
module timer_mc #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [11:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] irq
);

  localparam logic [4:0] OFF_CR   = 5'h00;
  localparam logic [4:0] OFF_SR   = 5'h04;
  localparam logic [4:0] OFF_CNTR = 5'h08;
  localparam logic [4:0] OFF_CMPR = 5'h0c;
  localparam logic [4:0] OFF_IER  = 5'h10;
  localparam logic [4:0] OFF_ISR  = 5'h14;
  localparam logic [4:0] OFF_PSC  = 5'h18;

  localparam logic [WIDTH-1:0]     CNT_ONE = 1;
  localparam logic [PSC_WIDTH-1:0] PSC_ONE = 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q  [CHANNELS];
  state_e               state_d  [CHANNELS];
  logic [WIDTH-1:0]     cnt_q    [CHANNELS];
  logic [WIDTH-1:0]     cnt_d    [CHANNELS];
  logic [WIDTH-1:0]     cmp_q    [CHANNELS];
  logic [WIDTH-1:0]     cmp_d    [CHANNELS];
  logic [PSC_WIDTH-1:0] psc_q    [CHANNELS];
  logic [PSC_WIDTH-1:0] psc_d    [CHANNELS];
  logic [PSC_WIDTH-1:0] pcnt_q   [CHANNELS];
  logic [PSC_WIDTH-1:0] pcnt_d   [CHANNELS];
  logic                 sngl_q   [CHANNELS];
  logic                 sngl_d   [CHANNELS];
  logic                 mtch_q   [CHANNELS];
  logic                 mtch_d   [CHANNELS];
  logic                 mtchf_q  [CHANNELS];
  logic                 mtchf_d  [CHANNELS];
  logic                 mtchie_q [CHANNELS];
  logic                 mtchie_d [CHANNELS];
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_d;

  logic                sel_ok;
  logic [2:0]          sel_ch;
  logic [4:0]          sel_off;
  logic [CHANNELS-1:0] wr_ch;
  logic [CHANNELS-1:0] trg;
  logic [CHANNELS-1:0] hlt;
  logic [CHANNELS-1:0] w1c;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] act;
  logic [31:0]         rd_val;

  // Address decode and per-channel strobes (write, trigger, halt, tick, match).
  always_comb begin
    sel_ch  = addr[7:5];
    sel_off = addr[4:0];
    sel_ok  = (addr[11:8] == 4'h0) && (int'(sel_ch) < CHANNELS);
    for (int i = 0; i < CHANNELS; i++) begin
      wr_ch[i] = wr_en && sel_ok && (int'(sel_ch) == i);
      trg[i]   = wr_ch[i] && (sel_off == OFF_CR)  && wdata[0];
      hlt[i]   = wr_ch[i] && (sel_off == OFF_CR)  && wdata[1];
      w1c[i]   = wr_ch[i] && (sel_off == OFF_ISR) && wdata[0];
      // >= rather than == so a PSC lowered mid-count cannot strand the prescaler.
      tick[i]  = (state_q[i] == RUN) && (pcnt_q[i] >= psc_q[i]);
      hit[i]   = tick[i] && (cnt_q[i] == cmp_q[i]);
    end
  end

  // Channel FSM next state: halt beats trigger, trigger beats a single-shot stop.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: if (trg[i] && !hlt[i]) state_d[i] = RUN;
        RUN: begin
          if (hlt[i])                      state_d[i] = IDLE;
          else if (trg[i])                 state_d[i] = RUN;
          else if (hit[i] && sngl_q[i])    state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Counter, prescaler, flag and register next values; CPU writes override ticks.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i];
      cmp_d[i]    = cmp_q[i];
      psc_d[i]    = psc_q[i];
      pcnt_d[i]   = pcnt_q[i];
      sngl_d[i]   = sngl_q[i];
      mtch_d[i]   = mtch_q[i];
      mtchie_d[i] = mtchie_q[i];

      if (state_q[i] == RUN) begin
        pcnt_d[i] = tick[i] ? '0 : pcnt_q[i] + PSC_ONE;
      end
      if (hit[i]) begin
        cnt_d[i]  = '0;
        mtch_d[i] = 1'b1;
      end else if (tick[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      if (wr_ch[i]) begin
        case (sel_off)
          OFF_CR: begin
            sngl_d[i] = wdata[2];
            if (trg[i]) begin
              cnt_d[i]  = '0;
              pcnt_d[i] = '0;
              mtch_d[i] = 1'b0;
            end
          end
          OFF_CNTR: begin
            cnt_d[i]  = wdata[WIDTH-1:0];
            pcnt_d[i] = '0;
          end
          OFF_CMPR: cmp_d[i]    = wdata[WIDTH-1:0];
          OFF_IER:  mtchie_d[i] = wdata[0];
          OFF_PSC:  psc_d[i]    = wdata[PSC_WIDTH-1:0];
          default: ;
        endcase
      end

      // A new match takes priority over a same-cycle clear.
      mtchf_d[i] = hit[i] ? 1'b1 : (w1c[i] ? 1'b0 : mtchf_q[i]);
    end
  end

  // Outputs: activity, interrupt lines and the read mux (pre-write register values).
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      act[i] = (state_q[i] == RUN);
      irq[i] = mtchf_q[i] & mtchie_q[i];
      if (sel_ok && (int'(sel_ch) == i)) begin
        case (sel_off)
          OFF_CR:   rd_val = {29'd0, sngl_q[i], 2'b00};
          OFF_SR:   rd_val = {30'd0, act[i], mtch_q[i]};
          OFF_CNTR: rd_val = 32'(cnt_q[i]);
          OFF_CMPR: rd_val = 32'(cmp_q[i]);
          OFF_IER:  rd_val = {31'd0, mtchie_q[i]};
          OFF_ISR:  rd_val = {31'd0, mtchf_q[i]};
          OFF_PSC:  rd_val = 32'(psc_q[i]);
          default:  rd_val = '0;
        endcase
      end
    end
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  assign rdata = rdata_q;

  // State and register flops; reset forces every channel idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= IDLE;
        cnt_q[i]    <= '0;
        cmp_q[i]    <= '0;
        psc_q[i]    <= '0;
        pcnt_q[i]   <= '0;
        sngl_q[i]   <= 1'b0;
        mtch_q[i]   <= 1'b0;
        mtchf_q[i]  <= 1'b0;
        mtchie_q[i] <= 1'b0;
      end
    end else begin
      rdata_q <= rdata_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        cmp_q[i]    <= cmp_d[i];
        psc_q[i]    <= psc_d[i];
        pcnt_q[i]   <= pcnt_d[i];
        sngl_q[i]   <= sngl_d[i];
        mtch_q[i]   <= mtch_d[i];
        mtchf_q[i]  <= mtchf_d[i];
        mtchie_q[i] <= mtchie_d[i];
      end
    end
  end

endmodule
